// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: hex encoding, per-digit blanking gap,
// frame-aligned double buffering and optional leading-zero suppression.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 8,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    in_valid,
    input  logic                    lz_blank,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done,
    output logic                    pending
);
    localparam int MAX_PHASE = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(NUM_DIGITS - 1);
    localparam logic             INV       = (SEG_ACTIVE_LOW != 0);

    typedef enum logic {DWELL, GAP} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic                    phase_end, frame_end, last_q;
    logic [4*NUM_DIGITS-1:0] active_dig, buf_dig, act_dig_nxt;
    logic [NUM_DIGITS-1:0]   active_dp, buf_dp, act_dp_nxt;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              cur_dig;
    logic [7:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   dig_nxt;

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: enc = 7'b1111110;
            4'h1: enc = 7'b0110000;
            4'h2: enc = 7'b1101101;
            4'h3: enc = 7'b1111001;
            4'h4: enc = 7'b0110011;
            4'h5: enc = 7'b1011011;
            4'h6: enc = 7'b1011111;
            4'h7: enc = 7'b1110000;
            4'h8: enc = 7'b1111111;
            4'h9: enc = 7'b1111011;
            4'hA: enc = 7'b1110111;
            4'hB: enc = 7'b0011111;
            4'hC: enc = 7'b1001110;
            4'hD: enc = 7'b0111101;
            4'hE: enc = 7'b1001111;
            default: enc = 7'b1000111;
        endcase
    endfunction

    // The state registers hold the phase shown in the cycle after the next edge,
    // so seg_out/dig_sel are loaded from the current state with no added lag.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        phase_end = 1'b0;
        case (state)
            DWELL: if (cnt == DWELL_END) begin
                phase_end = 1'b1;
                cnt_nxt   = '0;
                if (BLANK_CYCLES > 0) state_nxt = GAP;
                else                  idx_nxt   = (idx == IDX_END) ? '0 : idx + 1'b1;
            end
            GAP: if (cnt == GAP_END) begin
                phase_end = 1'b1;
                cnt_nxt   = '0;
                state_nxt = DWELL;
                idx_nxt   = (idx == IDX_END) ? '0 : idx + 1'b1;
            end
            default: state_nxt = DWELL;
        endcase
        frame_end = phase_end && (idx == IDX_END) && (state == GAP || BLANK_CYCLES == 0);
    end

    // Active contents for the phase being latched; last_q marks the boundary cycle.
    always_comb begin
        act_dig_nxt = active_dig;
        act_dp_nxt  = active_dp;
        if (last_q) begin
            if (in_valid) begin
                act_dig_nxt = digits_in;
                act_dp_nxt  = dp_in;
            end else if (pending) begin
                act_dig_nxt = buf_dig;
                act_dp_nxt  = buf_dp;
            end
        end
    end

    always_comb begin
        logic lead;
        lead  = lz_blank;
        blank = '0;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            lead = lead && (act_dig_nxt[4*(NUM_DIGITS-1-k) +: 4] == 4'h0) && !act_dp_nxt[NUM_DIGITS-1-k];
            blank[NUM_DIGITS-1-k] = lead;
        end
    end

    always_comb begin
        cur_dig = act_dig_nxt[{idx, 2'b00} +: 4];
        seg_nxt = '0;
        dig_nxt = '0;
        if (state == DWELL) begin
            dig_nxt = NUM_DIGITS'(1) << idx;
            if (!blank[idx]) seg_nxt = {enc(cur_dig), act_dp_nxt[idx]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DWELL;
            cnt        <= '0;
            idx        <= '0;
            active_dig <= '0;
            active_dp  <= '0;
            buf_dig    <= '0;
            buf_dp     <= '0;
            pending    <= 1'b0;
            last_q     <= 1'b0;
            frame_done <= 1'b0;
            seg_out    <= {8{INV}};
            dig_sel    <= {NUM_DIGITS{INV}};
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            active_dig <= act_dig_nxt;
            active_dp  <= act_dp_nxt;
            if (in_valid) begin
                buf_dig <= digits_in;
                buf_dp  <= dp_in;
            end
            if (last_q)        pending <= 1'b0;
            else if (in_valid) pending <= 1'b1;
            last_q     <= frame_end;
            frame_done <= last_q;
            seg_out    <= seg_nxt ^ {8{INV}};
            dig_sel    <= dig_nxt ^ {NUM_DIGITS{INV}};
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: cycle model built from frame position arithmetic,
// with an active-high and an active-low instance driven in parallel.
module tb_seven_seg_scan_driver;
    localparam int ND = 6;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int SLOT = SD + BC;
    localparam int FR = ND * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4*ND-1:0] digits_in = '0;
    logic [ND-1:0] dp_in = '0;
    logic in_valid = 1'b0;
    logic lz_blank = 1'b0;
    logic [7:0] seg_out, seg_out_n;
    logic [ND-1:0] dig_sel, dig_sel_n;
    logic frame_done, frame_done_n, pending, pending_n;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .in_valid(in_valid),
        .lz_blank(lz_blank), .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done), .pending(pending));

    seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1)) dut_n (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .in_valid(in_valid),
        .lz_blank(lz_blank), .seg_out(seg_out_n), .dig_sel(dig_sel_n), .frame_done(frame_done_n), .pending(pending_n));

    int tests = 0;
    int fails = 0;

    // Reference state: n counts cycles since reset release (0 = first cycle after the reset edge).
    int n;
    logic [4*ND-1:0] shown_d, buf_d;
    logic [ND-1:0] shown_dp, buf_dp;
    bit pend;
    logic [7:0] exp_seg;
    logic [ND-1:0] exp_dig;
    logic exp_fd, exp_pend;

    logic [6:0] enc_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    function automatic logic [7:0] pattern(input int dg, input bit lz);
        bit lead;
        logic [3:0] v;
        v = shown_d[4*dg +: 4];
        lead = lz && (dg != 0);
        for (int j = ND - 1; j >= dg; j--)
            if (shown_d[4*j +: 4] != 4'h0 || shown_dp[j]) lead = 1'b0;
        return lead ? 8'h00 : {enc_tab[v], shown_dp[dg]};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        shown_d = '0; shown_dp = '0; buf_d = '0; buf_dp = '0; pend = 1'b0;
        exp_seg = '0; exp_dig = '0; exp_fd = 1'b0; exp_pend = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the reference across the edge, and
    // leaves the expected outputs for the new cycle in exp_*.
    task automatic tick(input bit v, input logic [4*ND-1:0] d, input logic [ND-1:0] dp, input bit lz);
        bit boundary;
        int p;
        in_valid = v; digits_in = d; dp_in = dp; lz_blank = lz;
        @(posedge clk);
        boundary = (n >= 1) && ((n - 1) % FR == FR - 1);
        if (boundary) begin
            if (v) begin shown_d = d; shown_dp = dp; end
            else if (pend) begin shown_d = buf_d; shown_dp = buf_dp; end
            pend = 1'b0;
        end else if (v) begin
            buf_d = d; buf_dp = dp; pend = 1'b1;
        end
        n++;
        #1;
        in_valid = 1'b0;
        p = (n - 1) % FR;
        if (p % SLOT >= SD) begin
            exp_seg = '0;
            exp_dig = '0;
        end else begin
            exp_dig = ND'(1) << (p / SLOT);
            exp_seg = pattern(p / SLOT, lz);
        end
        exp_fd = (n > FR) && (p == 0);
        exp_pend = pend;
    endtask

    function automatic bit at_boundary();
        return (n >= 1) && ((n - 1) % FR == FR - 1);
    endfunction

    task automatic test_reset();
        do_reset();
        tests++;
        if ({seg_out, dig_sel, frame_done, pending} !== {8'h00, 6'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_hi got seg=%h dig=%b fd=%b pend=%b exp seg=00 dig=000000 fd=0 pend=0", seg_out, dig_sel, frame_done, pending);
        end
        tests++;
        if ({seg_out_n, dig_sel_n, frame_done_n, pending_n} !== {8'hFF, 6'b111111, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_lo got seg=%h dig=%b fd=%b pend=%b exp seg=ff dig=111111 fd=0 pend=0", seg_out_n, dig_sel_n, frame_done_n, pending_n);
        end
        tick(1'b0, '0, '0, 1'b0);
        tests++;
        if ({seg_out, dig_sel} !== {8'hFC, 6'b000001}) begin
            fails++;
            $display("FAIL first_cycle got seg=%h dig=%b exp seg=fc dig=000001", seg_out, dig_sel);
        end
    endtask

    task automatic test_scan_timing();
        int fd_count = 0;
        do_reset();
        for (int i = 0; i < 2 * FR + 3; i++) begin
            tick(1'b0, '0, '0, 1'b0);
            if (frame_done === 1'b1) fd_count++;
            tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {exp_seg, exp_dig, exp_fd, exp_pend}) begin
                fails++;
                $display("FAIL scan_timing cyc=%0d got seg=%h dig=%b fd=%b pend=%b exp seg=%h dig=%b fd=%b pend=%b",
                         n, seg_out, dig_sel, frame_done, pending, exp_seg, exp_dig, exp_fd, exp_pend);
            end
        end
        tests++;
        if (fd_count !== 2) begin
            fails++;
            $display("FAIL frame_done_count got=%0d exp=2", fd_count);
        end
    endtask

    task automatic test_update_midframe();
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b0, '0, '0, 1'b0);
        tick(1'b1, 24'h123456, 6'b000100, 1'b0);
        tests++;
        if (pending !== 1'b1) begin
            fails++;
            $display("FAIL midframe_pending got=%b exp=1", pending);
        end
        for (int i = 0; i < 2 * FR; i++) begin
            tick(1'b0, '0, '0, 1'b0);
            tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {exp_seg, exp_dig, exp_fd, exp_pend}) begin
                fails++;
                $display("FAIL midframe cyc=%0d got seg=%h dig=%b fd=%b pend=%b exp seg=%h dig=%b fd=%b pend=%b",
                         n, seg_out, dig_sel, frame_done, pending, exp_seg, exp_dig, exp_fd, exp_pend);
            end
            if (n == FR + 1) begin
                tests++;
                if (seg_out !== 8'hBE) begin
                    fails++;
                    $display("FAIL midframe_digit0 got=%h exp=be", seg_out);
                end
            end
        end
    endtask

    task automatic test_lz_blank(input logic [4*ND-1:0] val, input logic [7:0] dig0_seg);
        do_reset();
        tick(1'b1, val, '0, 1'b1);
        for (int i = 0; i < 2 * FR; i++) begin
            tick(1'b0, '0, '0, 1'b1);
            tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {exp_seg, exp_dig, exp_fd, exp_pend}) begin
                fails++;
                $display("FAIL lz_blank val=%h cyc=%0d got seg=%h dig=%b exp seg=%h dig=%b",
                         val, n, seg_out, dig_sel, exp_seg, exp_dig);
            end
            if (n == FR + 1) begin
                tests++;
                if (seg_out !== dig0_seg) begin
                    fails++;
                    $display("FAIL lz_digit0 val=%h got=%h exp=%h", val, seg_out, dig0_seg);
                end
            end
            if (n > FR && dig_sel[ND-1] === 1'b1) begin
                tests++;
                if (seg_out !== 8'h00) begin
                    fails++;
                    $display("FAIL lz_digit5 val=%h got=%h exp=00", val, seg_out);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, '0, '0, 1'b0);
        tick(1'b1, 24'h111111, 6'b000000, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, '0, 1'b0);
        tick(1'b1, 24'hFFFFFF, 6'b000001, 1'b0);
        for (int i = 0; i < FR; i++) begin
            tick(1'b0, '0, '0, 1'b0);
            tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {exp_seg, exp_dig, exp_fd, exp_pend}) begin
                fails++;
                $display("FAIL back_to_back cyc=%0d got seg=%h dig=%b fd=%b pend=%b exp seg=%h dig=%b fd=%b pend=%b",
                         n, seg_out, dig_sel, frame_done, pending, exp_seg, exp_dig, exp_fd, exp_pend);
            end
            if (n == FR + 1) begin
                tests++;
                if (seg_out !== 8'h8F) begin
                    fails++;
                    $display("FAIL back_to_back_digit0 got=%h exp=8f", seg_out);
                end
            end
        end
    endtask

    task automatic test_boundary_strobe();
        int pend_seen = 0;
        do_reset();
        tick(1'b0, '0, '0, 1'b0);
        while (!at_boundary()) tick(1'b0, '0, '0, 1'b0);
        tick(1'b1, 24'hA5C3E7, 6'b100010, 1'b0);
        for (int i = 0; i < FR; i++) begin
            if (pending !== 1'b0) pend_seen++;
            tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {exp_seg, exp_dig, exp_fd, exp_pend}) begin
                fails++;
                $display("FAIL boundary_strobe cyc=%0d got seg=%h dig=%b fd=%b pend=%b exp seg=%h dig=%b fd=%b pend=%b",
                         n, seg_out, dig_sel, frame_done, pending, exp_seg, exp_dig, exp_fd, exp_pend);
            end
            tick(1'b0, '0, '0, 1'b0);
        end
        tests++;
        if (pend_seen !== 0) begin
            fails++;
            $display("FAIL boundary_pending got=%0d cycles exp=0", pend_seen);
        end
    endtask

    task automatic test_reset_mid_gap();
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b0, '0, '0, 1'b0);
        tick(1'b1, 24'h987654, 6'b111111, 1'b0);
        while (exp_dig != '0) tick(1'b0, '0, '0, 1'b0);
        do_reset();
        tests++;
        if ({seg_out, dig_sel, frame_done, pending} !== {8'h00, 6'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_gap got seg=%h dig=%b fd=%b pend=%b exp seg=00 dig=000000 fd=0 pend=0", seg_out, dig_sel, frame_done, pending);
        end
        for (int i = 0; i < FR + 2; i++) begin
            tick(1'b0, '0, '0, 1'b0);
            tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {exp_seg, exp_dig, exp_fd, exp_pend}) begin
                fails++;
                $display("FAIL after_gap_reset cyc=%0d got seg=%h dig=%b fd=%b pend=%b exp seg=%h dig=%b fd=%b pend=%b",
                         n, seg_out, dig_sel, frame_done, pending, exp_seg, exp_dig, exp_fd, exp_pend);
            end
        end
    endtask

    task automatic test_random();
        bit v, lz;
        logic [4*ND-1:0] d;
        logic [ND-1:0] dp;
        do_reset();
        lz = 1'b0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) == 0);
            d = 24'($urandom);
            if ($urandom_range(0, 2) == 0) d = d & 24'h00F00F;
            dp = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            if ($urandom_range(0, 19) == 0) lz = ~lz;
            tick(v, d, dp, lz);
            tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {exp_seg, exp_dig, exp_fd, exp_pend}) begin
                fails++;
                $display("FAIL random_hi cyc=%0d got seg=%h dig=%b fd=%b pend=%b exp seg=%h dig=%b fd=%b pend=%b",
                         n, seg_out, dig_sel, frame_done, pending, exp_seg, exp_dig, exp_fd, exp_pend);
            end
            tests++;
            if ({seg_out_n, dig_sel_n, frame_done_n, pending_n} !== {~exp_seg, ~exp_dig, exp_fd, exp_pend}) begin
                fails++;
                $display("FAIL random_lo cyc=%0d got seg=%h dig=%b fd=%b pend=%b exp seg=%h dig=%b fd=%b pend=%b",
                         n, seg_out_n, dig_sel_n, frame_done_n, pending_n, ~exp_seg, ~exp_dig, exp_fd, exp_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_update_midframe();
        test_lz_blank(24'h000042, 8'hDA);
        test_lz_blank(24'h000000, 8'hFC);
        test_back_to_back();
        test_boundary_strobe();
        test_reset_mid_gap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
